// File: rtl/mips_mem_pkg.sv
// Shared memory-stage definitions for the MIPS data path.
//   stb_entry_t       : one buffered store (word address + data)
//   STB_DEPTH_DEFAULT : default store buffer depth
//   STB_AW            : byte-address width the entry layout is sized for
//   word_idx()        : byte address -> word index (drops addr[1:0])
package mips_mem_pkg;

    localparam int unsigned STB_DEPTH_DEFAULT = 4;
    localparam int unsigned STB_AW            = 32;

    typedef struct packed {
        logic [STB_AW-3:0] addr;
        logic [31:0]       data;
    } stb_entry_t;

    function automatic logic [STB_AW-3:0] word_idx(input logic [STB_AW-1:0] addr);
        return addr[STB_AW-1:2];
    endfunction

endpackage

// File: rtl/stb_fifo.sv
// Entry storage for the store buffer: circular FIFO with head/tail/count.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_entry at tail (ignored when full)
//   push_entry  : entry to enqueue
//   pop         : retire head entry (ignored when empty)
//   head_entry  : oldest entry
//   entries     : raw storage, indexed by physical slot
//   head        : physical slot of the oldest entry
//   count       : entries occupied
//   full, empty : occupancy flags
module stb_fifo
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = STB_DEPTH_DEFAULT,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  stb_entry_t       push_entry,
    input  logic             pop,
    output stb_entry_t       head_entry,
    output stb_entry_t       entries [DEPTH],
    output logic [PW-1:0]    head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    stb_entry_t    mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage needs no reset: validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) tail_q <= tail_q + PW'(1);
            if (pop_ok)  head_q <= head_q + PW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    assign head_entry = mem_q[head_q];
    assign entries    = mem_q;
    assign head       = head_q;
    assign count      = count_q;

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer between EX/MEM and the data memory.
// Stores are queued and drained in program order whenever the memory port
// is not taken by a load; loads look up the buffer by word index first.
// Optional feature: define STORE_BUFFER_FWD_EN to forward buffered data to
// hitting loads. Without it a hitting load stalls until no entry matches.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   st_valid/st_addr/st_data  : store request
//   ld_valid/ld_addr          : load request
//   ld_data                   : load result (combinational, 0 when no load done)
//   stall                     : request not accepted/completed this cycle
//   mem_write/waddr/wdata     : data-memory write port (drain)
//   mem_read/raddr/rdata      : data-memory read port (load miss)
//   count                     : entries occupied
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = STB_DEPTH_DEFAULT,
    parameter int unsigned AW    = STB_AW,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic [31:0]   ld_data,
    output logic          stall,
    output logic          mem_write,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          mem_read,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata,
    output logic [CW-1:0] count
);

    stb_entry_t    head_entry;
    stb_entry_t    entries [DEPTH];
    stb_entry_t    push_entry;
    logic [PW-1:0] head;
    logic          full, empty;
    logic          push, drain;
    logic          hit, ld_hit, ld_block, load_mem;
    logic [31:0]   fwd_data;

    assign push_entry.addr = word_idx(st_addr);
    assign push_entry.data = st_data;

    // A full buffer refuses the store even if the head drains this cycle.
    assign push = st_valid && !full;

    stb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head_entry (head_entry),
        .entries    (entries),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Walk oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count &&
                entries[head + PW'(i)].addr == word_idx(ld_addr)) begin
                hit      = 1'b1;
                fwd_data = entries[head + PW'(i)].data;
            end
        end
    end

    assign ld_hit = ld_valid && hit;

`ifdef STORE_BUFFER_FWD_EN
    assign ld_block = 1'b0;
`else
    // Memory may be stale for this word until the matching stores drain.
    assign ld_block = ld_hit;
`endif

    // A full buffer gives the port to the drain so the pipeline can progress.
    assign load_mem = ld_valid && !ld_hit && !full;
    assign drain    = !empty && !load_mem;

    assign stall = (st_valid && full) ||
                   (ld_valid && ((!ld_hit && full) || ld_block));

    always_comb begin
        ld_data = '0;
        if (load_mem)                ld_data = mem_rdata;
        else if (ld_hit && !ld_block) ld_data = fwd_data;
    end

    assign mem_read  = load_mem;
    assign mem_raddr = ld_addr;
    assign mem_write = drain;
    assign mem_waddr = {head_entry.addr, 2'b00};
    assign mem_wdata = head_entry.data;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk, rst;
    logic        st_valid, ld_valid;
    logic [31:0] st_addr, st_data, ld_addr, ld_data;
    logic        stall, mem_write, mem_read;
    logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
    logic [2:0]  count;

    store_buffer #(
        .DEPTH (DEPTH),
        .AW    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .stall     (stall),
        .mem_write (mem_write),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory (what the DUT actually wrote) and reference memory
    // (what program-order retirement of accepted stores should produce).
    logic [31:0] env_mem [16];
    logic [31:0] ref_mem [16];
    assign mem_rdata = env_mem[mem_raddr[5:2]];

    typedef struct {
        int unsigned w;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) begin
        if (!rst) assert (!(st_valid && ld_valid));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: drive, check combinational outputs against the model, clock.
    task automatic step(input bit st, input bit ld, input logic [31:0] a, input logic [31:0] d);
        bit          full, hit, e_rd, e_wr, e_stall, wr_seen;
        logic [31:0] e_ld, fwd, wa, wd;
        int          n;
        st_valid = st;
        ld_valid = ld;
        st_addr  = a;
        ld_addr  = a;
        st_data  = d;
        #2;
        n    = q.size();
        full = (n == DEPTH);
        hit  = 1'b0;
        fwd  = 32'h0;
        if (ld) begin
            foreach (q[i]) begin
                if (q[i].w == int'(a[31:2])) begin
                    hit = 1'b1;
                    fwd = q[i].d;
                end
            end
        end
        e_rd = ld && !hit && !full;
`ifdef STORE_BUFFER_FWD_EN
        e_stall = (ld && !hit && full) || (st && full);
        e_ld    = e_rd ? ref_mem[a[5:2]] : (hit ? fwd : 32'h0);
`else
        e_stall = (ld && (hit || full)) || (st && full);
        e_ld    = e_rd ? ref_mem[a[5:2]] : 32'h0;
`endif
        e_wr = (n > 0) && !e_rd;
        check("stall", {31'b0, stall}, {31'b0, e_stall});
        check("mem_read", {31'b0, mem_read}, {31'b0, e_rd});
        check("mem_write", {31'b0, mem_write}, {31'b0, e_wr});
        check("ld_data", ld_data, e_ld);
        check("count", {29'b0, count}, n);
        if (e_rd) check("mem_raddr", mem_raddr, a);
        if (e_wr) begin
            check("mem_waddr", mem_waddr, q[0].w << 2);
            check("mem_wdata", mem_wdata, q[0].d);
        end
        wr_seen = mem_write;
        wa      = mem_waddr;
        wd      = mem_wdata;
        @(posedge clk);
        if (wr_seen) env_mem[wa[5:2]] = wd;
        if (e_wr) begin
            ref_mem[q[0].w % 16] = q[0].d;
            void'(q.pop_front());
        end
        if (st && !full) q.push_back('{a[31:2], d});
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        int          op;
        rst      = 1'b1;
        st_valid = 1'b0;
        ld_valid = 1'b0;
        st_addr  = '0;
        ld_addr  = '0;
        st_data  = '0;
        for (int i = 0; i < 16; i++) begin
            v          = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[0] = 32'h1;
        ref_mem[0] = 32'h1;

        // Reset state
        #1;
        check("rst_count", {29'b0, count}, 32'h0);
        check("rst_mem_write", {31'b0, mem_write}, 32'h0);
        check("rst_mem_read", {31'b0, mem_read}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single store drains on the following idle cycle
        step(1'b1, 1'b0, 32'h28, 32'h55AA55AA);
        idle();
        idle();
        check("drain_empty", {29'b0, count}, 32'h0);

        // Two stores to one word, then a load with a different byte offset
        step(1'b1, 1'b0, 32'h2C, 32'h11);
        step(1'b1, 1'b0, 32'h2C, 32'h22);
        step(1'b0, 1'b1, 32'h2E, 32'h0);
        step(1'b0, 1'b1, 32'h2E, 32'h0);
        step(1'b0, 1'b1, 32'h2E, 32'h0);
        check("fwd_final", ld_data, 32'h22);

        // Load miss holds off a pending store
        step(1'b1, 1'b0, 32'h10, 32'hA5A5);
        step(1'b0, 1'b1, 32'h00, 32'h0);
        step(1'b0, 1'b1, 32'h01, 32'h0);
        idle();

        // Stores interleaved with back-to-back loads
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h30 + 32'(i * 4), 32'h100 + 32'(i));
            step(1'b0, 1'b1, 32'h04, 32'h0);
            step(1'b0, 1'b1, 32'h08, 32'h0);
        end
        idle();

        // Reset with a store pending: discarded, never written
        step(1'b1, 1'b0, 32'h3C, 32'hDEAD);
        rst = 1'b1;
        #1;
        check("midrst_count", {29'b0, count}, 32'h0);
        check("midrst_mem_write", {31'b0, mem_write}, 32'h0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        step(1'b0, 1'b1, 32'h3C, 32'h0);

        // Pointer wrap: nine store/drain pairs
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 32'(i * 4), 32'h200 + 32'(i));
            idle();
        end
        check("wrap_count", {29'b0, count}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 2));
            step(op == 1, op == 2, 32'($urandom_range(0, 63)), $urandom);
        end
        for (int i = 0; i < 6; i++) idle();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 32'(i * 4), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
